// File: rtl/glb_wr_packer_pkg.sv
// Shared GLB definitions: packer FSM state encoding and default geometry
// common to the GLB write-port logic.
package glb_wr_packer_pkg;

   localparam int unsigned GLB_SRAM_WIDTH = 256;
   localparam int unsigned GLB_MAXPAR     = 32;
   localparam int unsigned GLB_ADDR_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      SEND = 2'd2
   } glb_state_e;

endpackage

// File: rtl/glb_wr_packer_lane_buf.sv
// MAXPAR-lane register file feeding the wide GLB write beat; each lane has its
// own write enable, and a synchronous clear zeroes every lane at once.
module glb_lane_buf #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned LANES = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic [LANES-1:0]       wr_en,
   input  logic [WIDTH-1:0]       wr_dat,
   output logic [WIDTH*LANES-1:0] dat
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         dat <= '0;
      end else begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (wr_en[i]) dat[i*WIDTH +: WIDTH] <= wr_dat;
         end
      end
   end

endmodule

// File: rtl/glb_wr_packer.sv
// Packs narrow input words into MAXPAR-lane beats for the GLB write port;
// groups of P words (or fewer at end of transfer) become one beat.
module glb_wr_packer
   import glb_wr_packer_pkg::*;
#(
   parameter int unsigned SRAM_WIDTH = GLB_SRAM_WIDTH,
   parameter int unsigned MAXPAR     = GLB_MAXPAR,
   parameter int unsigned ADDR_WIDTH = GLB_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         CfgVld,
   output logic                         CfgRdy,
   input  logic [$clog2(MAXPAR):0]      CfgParBank,
   input  logic [ADDR_WIDTH-1:0]        CfgNumWord,
   input  logic [SRAM_WIDTH-1:0]        InDat,
   input  logic                         InDatVld,
   input  logic                         InDatLast,
   output logic                         InDatRdy,
   output logic [SRAM_WIDTH*MAXPAR-1:0] WrPortDat,
   output logic                         WrPortDatVld,
   output logic                         WrPortDatLast,
   input  logic                         WrPortDatRdy,
   output logic [ADDR_WIDTH-1:0]        WordCnt
);

   localparam int unsigned PW = $clog2(MAXPAR) + 1;

   glb_state_e            state;
   logic [PW-1:0]         par_lat;
   logic [PW-1:0]         par_clamp;
   logic [PW-1:0]         lane_idx;
   logic [ADDR_WIDTH-1:0] num_lat;
   logic [ADDR_WIDTH-1:0] word_cnt_inc;
   logic                  cfg_hs;
   logic                  in_hs;
   logic                  out_hs;
   logic                  grp_last;
   logic                  grp_end;
   logic                  buf_clr;
   logic [MAXPAR-1:0]     lane_we;

   always_comb begin
      par_clamp = CfgParBank;
      if (CfgParBank == '0)
         par_clamp = PW'(1);
      else if (CfgParBank > PW'(MAXPAR))
         par_clamp = PW'(MAXPAR);
   end

   // CfgRdy/InDatRdy are registered copies of the state, so handshakes
   // qualify on them without any path from WrPortDatRdy.
   assign cfg_hs       = CfgVld & CfgRdy;
   assign in_hs        = InDatVld & InDatRdy;
   assign out_hs       = WrPortDatVld & WrPortDatRdy;
   assign word_cnt_inc = WordCnt + 1'b1;
   assign grp_last     = InDatLast | (word_cnt_inc == num_lat);
   assign grp_end      = (lane_idx == par_lat - 1'b1) | grp_last;
   assign buf_clr      = cfg_hs | out_hs;

   always_comb begin
      lane_we = '0;
      for (int unsigned i = 0; i < MAXPAR; i++) begin
         lane_we[i] = in_hs && (lane_idx == PW'(i));
      end
   end

   glb_lane_buf #(
      .WIDTH (SRAM_WIDTH),
      .LANES (MAXPAR)
   ) u_lane_buf (
      .clk    (clk),
      .rst    (rst),
      .clr    (buf_clr),
      .wr_en  (lane_we),
      .wr_dat (InDat),
      .dat    (WrPortDat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         CfgRdy        <= 1'b1;
         InDatRdy      <= 1'b0;
         WrPortDatVld  <= 1'b0;
         WrPortDatLast <= 1'b0;
         WordCnt       <= '0;
         lane_idx      <= '0;
         par_lat       <= PW'(1);
         num_lat       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (CfgVld) begin
                  par_lat  <= par_clamp;
                  num_lat  <= CfgNumWord;
                  WordCnt  <= '0;
                  lane_idx <= '0;
                  // An empty transfer never leaves IDLE.
                  if (CfgNumWord != '0) begin
                     state    <= FILL;
                     CfgRdy   <= 1'b0;
                     InDatRdy <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (InDatVld) begin
                  lane_idx <= lane_idx + 1'b1;
                  WordCnt  <= word_cnt_inc;
                  if (grp_end) begin
                     state         <= SEND;
                     InDatRdy      <= 1'b0;
                     WrPortDatVld  <= 1'b1;
                     WrPortDatLast <= grp_last;
                  end
               end
            end
            SEND: begin
               if (WrPortDatRdy) begin
                  lane_idx      <= '0;
                  WrPortDatVld  <= 1'b0;
                  WrPortDatLast <= 1'b0;
                  if (WrPortDatLast) begin
                     state  <= IDLE;
                     CfgRdy <= 1'b1;
                  end else begin
                     state    <= FILL;
                     InDatRdy <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_glb_wr_packer.sv
// Directed bench for glb_wr_packer with a narrow lane width so beats stay readable.
module tb_glb_wr_packer;

   localparam int unsigned SW = 16;
   localparam int unsigned MP = 32;
   localparam int unsigned AW = 16;
   localparam int unsigned PW = $clog2(MP) + 1;
   localparam int unsigned BW = SW * MP;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          CfgVld = 1'b0;
   logic          CfgRdy;
   logic [PW-1:0] CfgParBank = '0;
   logic [AW-1:0] CfgNumWord = '0;
   logic [SW-1:0] InDat = '0;
   logic          InDatVld = 1'b0;
   logic          InDatLast = 1'b0;
   logic          InDatRdy;
   logic [BW-1:0] WrPortDat;
   logic          WrPortDatVld;
   logic          WrPortDatLast;
   logic          WrPortDatRdy = 1'b1;
   logic [AW-1:0] WordCnt;

   int unsigned checks = 0;
   int unsigned failures = 0;

   logic [BW-1:0] beat_q[$];
   logic          last_q[$];

   glb_wr_packer #(
      .SRAM_WIDTH (SW),
      .MAXPAR     (MP),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .CfgVld        (CfgVld),
      .CfgRdy        (CfgRdy),
      .CfgParBank    (CfgParBank),
      .CfgNumWord    (CfgNumWord),
      .InDat         (InDat),
      .InDatVld      (InDatVld),
      .InDatLast     (InDatLast),
      .InDatRdy      (InDatRdy),
      .WrPortDat     (WrPortDat),
      .WrPortDatVld  (WrPortDatVld),
      .WrPortDatLast (WrPortDatLast),
      .WrPortDatRdy  (WrPortDatRdy),
      .WordCnt       (WordCnt)
   );

   always #5 clk = ~clk;

   // Inputs change at posedge+1, so a handshake seen at negedge completes on the next posedge.
   always @(negedge clk) begin
      if (WrPortDatVld && WrPortDatRdy) begin
         beat_q.push_back(WrPortDat);
         last_q.push_back(WrPortDatLast);
      end
   end

   task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [BW-1:0] mk_beat(input int unsigned first, input int unsigned cnt);
      logic [BW-1:0] b = '0;
      for (int unsigned i = 0; i < cnt; i++) b[i*SW +: SW] = SW'(first + i);
      return b;
   endfunction

   task automatic configure(input int unsigned p, input int unsigned n);
      @(posedge clk); #1;
      CfgParBank = PW'(p);
      CfgNumWord = AW'(n);
      CfgVld     = 1'b1;
      @(posedge clk); #1;
      CfgVld     = 1'b0;
   endtask

   task automatic push_word(input int unsigned w, input logic last);
      int unsigned guard = 0;
      InDat     = SW'(w);
      InDatVld  = 1'b1;
      InDatLast = last;
      @(negedge clk);
      while (!InDatRdy && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!InDatRdy) chk("in_rdy_timeout", 0, 1);
      @(posedge clk); #1;
      InDatVld  = 1'b0;
      InDatLast = 1'b0;
   endtask

   task automatic push_range(input int unsigned first, input int unsigned cnt);
      for (int unsigned i = 0; i < cnt; i++) push_word(first + i, 1'b0);
   endtask

   task automatic wait_idle();
      int unsigned guard = 0;
      @(negedge clk);
      while (!(CfgRdy && !WrPortDatVld) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) chk("idle_timeout", 0, 1);
   endtask

   task automatic expect_beat(input string tag, input int unsigned idx, input int unsigned first,
                              input int unsigned cnt, input logic last);
      if (idx < beat_q.size()) begin
         chk({tag, "_dat"}, beat_q[idx], mk_beat(first, cnt));
         chk({tag, "_last"}, BW'(last_q[idx]), BW'(last));
      end else begin
         chk({tag, "_missing"}, 0, 1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cfgrdy"}, BW'(CfgRdy), 1);
      chk({tag, "_inrdy"}, BW'(InDatRdy), 0);
      chk({tag, "_vld"}, BW'(WrPortDatVld), 0);
      chk({tag, "_last"}, BW'(WrPortDatLast), 0);
      chk({tag, "_dat"}, WrPortDat, '0);
      chk({tag, "_wcnt"}, BW'(WordCnt), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      // P=4, N=8: two full beats, the second also ends the transfer
      beat_q.delete(); last_q.delete();
      configure(4, 8);
      push_range(1, 8);
      wait_idle();
      chk("t1_nbeats", BW'(beat_q.size()), 2);
      expect_beat("t1_b0", 0, 1, 4, 1'b0);
      expect_beat("t1_b1", 1, 5, 4, 1'b1);
      chk("t1_cfgrdy", BW'(CfgRdy), 1);
      chk("t1_wcnt", BW'(WordCnt), 8);

      // P=4, N=6: short final beat with zeroed upper lanes
      beat_q.delete(); last_q.delete();
      configure(4, 6);
      push_range(1, 6);
      wait_idle();
      chk("t2_nbeats", BW'(beat_q.size()), 2);
      expect_beat("t2_b0", 0, 1, 4, 1'b0);
      expect_beat("t2_b1", 1, 5, 2, 1'b1);

      // P=4, N=100, InDatLast on word 3
      beat_q.delete(); last_q.delete();
      configure(4, 100);
      push_word(1, 1'b0);
      push_word(2, 1'b0);
      push_word(3, 1'b1);
      wait_idle();
      chk("t3_nbeats", BW'(beat_q.size()), 1);
      expect_beat("t3_b0", 0, 1, 3, 1'b1);
      chk("t3_wcnt", BW'(WordCnt), 3);

      // P=2, output stalled for 5 cycles in SEND
      beat_q.delete(); last_q.delete();
      WrPortDatRdy = 1'b0;
      configure(2, 2);
      push_range(1, 2);
      for (int unsigned i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_vld", BW'(WrPortDatVld), 1);
         chk("t4_dat", WrPortDat, mk_beat(1, 2));
         chk("t4_last", BW'(WrPortDatLast), 1);
         chk("t4_inrdy", BW'(InDatRdy), 0);
      end
      @(posedge clk); #1;
      WrPortDatRdy = 1'b1;
      wait_idle();
      chk("t4_nbeats", BW'(beat_q.size()), 1);

      // reset mid-group, then P=0 packs one word per beat
      beat_q.delete(); last_q.delete();
      configure(4, 4);
      push_range(1, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("t5_rst");
      chk("t5_nbeats_rst", BW'(beat_q.size()), 0);
      configure(0, 3);
      push_range(1, 3);
      wait_idle();
      chk("t5_nbeats", BW'(beat_q.size()), 3);
      expect_beat("t5_b0", 0, 1, 1, 1'b0);
      expect_beat("t5_b1", 1, 2, 1, 1'b0);
      expect_beat("t5_b2", 2, 3, 1, 1'b1);

      // CfgVld outside IDLE is ignored
      beat_q.delete(); last_q.delete();
      configure(2, 4);
      push_word(1, 1'b0);
      CfgParBank = PW'(4);
      CfgNumWord = AW'(1);
      CfgVld     = 1'b1;
      @(posedge clk); #1;
      CfgVld     = 1'b0;
      push_range(2, 3);
      wait_idle();
      chk("t6_nbeats", BW'(beat_q.size()), 2);
      expect_beat("t6_b0", 0, 1, 2, 1'b0);
      expect_beat("t6_b1", 1, 3, 2, 1'b1);
      chk("t6_wcnt", BW'(WordCnt), 4);

      // P above MAXPAR clamps to MAXPAR
      beat_q.delete(); last_q.delete();
      configure(40, 33);
      push_range(1, 33);
      wait_idle();
      chk("t7_nbeats", BW'(beat_q.size()), 2);
      expect_beat("t7_b0", 0, 1, 32, 1'b0);
      expect_beat("t7_b1", 1, 33, 1, 1'b1);

      // N=0: no beat, stays idle
      beat_q.delete(); last_q.delete();
      configure(4, 0);
      repeat (4) begin
         @(negedge clk);
         chk("t8_cfgrdy", BW'(CfgRdy), 1);
         chk("t8_inrdy", BW'(InDatRdy), 0);
      end
      chk("t8_nbeats", BW'(beat_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
